// File: rtl/store_write_combiner_if.sv
// Request/grant store channel: used for the store-buffer side and the D$ side of the combiner.
interface store_write_combiner_if #(
  parameter int unsigned PLEN = 56
);
  logic            req;
  logic            gnt;
  logic [PLEN-1:0] paddr;
  logic [63:0]     data;
  logic [7:0]      be;
  logic [1:0]      size;

  // master issues the store, slave grants it
  modport master (output req, paddr, data, be, size, input gnt);
  modport slave  (input req, paddr, data, be, size, output gnt);
endinterface

// File: rtl/store_write_combiner.sv
// Single-entry store write combiner: merges committed stores to the same doubleword
// before issuing one D$ write; flushes on address change, age timeout or drain.
module store_write_combiner #(
  parameter int unsigned PLEN     = 56,
  parameter int unsigned TIMEOUT  = 4,
  parameter bit          MERGE_EN = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  store_write_combiner_if.slave  s,
  store_write_combiner_if.master d,
  input  logic                  drain_i,
  input  logic [11:0]           page_offset_i,
  output logic                  page_offset_matches_o,
  output logic                  empty_o
);

  localparam int unsigned AgeW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {EMPTY, HOLD, ISSUE} state_e;

  state_e            state_q, state_d;
  logic [PLEN-1:0]   paddr_q, paddr_d;
  logic [63:0]       data_q, data_d;
  logic [7:0]        be_q, be_d;
  logic [1:0]        size_q, size_d;
  logic              merged_q, merged_d;
  logic [AgeW-1:0]   age_q, age_d;
  logic              same_word;
  logic              aged_out;

  assign same_word = (s.paddr[PLEN-1:3] == paddr_q[PLEN-1:3]);
  assign aged_out  = (age_q == AgeW'(TIMEOUT - 1));

  // Next-state, entry update and store-side grant
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    data_d   = data_q;
    be_d     = be_q;
    size_d   = size_q;
    merged_d = merged_q;
    age_d    = age_q;
    s.gnt    = 1'b0;

    unique case (state_q)
      EMPTY: begin
        if (s.req && !drain_i) begin
          s.gnt    = 1'b1;
          paddr_d  = s.paddr;
          data_d   = s.data;
          be_d     = s.be;
          size_d   = s.size;
          merged_d = 1'b0;
          age_d    = '0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        // drain and timeout win over merging
        if (drain_i || aged_out || !MERGE_EN) begin
          state_d = ISSUE;
        end else if (s.req && same_word) begin
          s.gnt = 1'b1;
          for (int unsigned i = 0; i < 8; i++) begin
            if (s.be[i]) data_d[8*i +: 8] = s.data[8*i +: 8];
          end
          be_d     = be_q | s.be;
          merged_d = 1'b1;
          age_d    = '0;
        end else if (s.req) begin
          state_d = ISSUE;
        end else begin
          age_d = age_q + AgeW'(1);
        end
      end
      ISSUE: begin
        if (d.gnt) begin
          if (s.req && !drain_i) begin
            // back-to-back refill in the retiring cycle
            s.gnt    = 1'b1;
            paddr_d  = s.paddr;
            data_d   = s.data;
            be_d     = s.be;
            size_d   = s.size;
            merged_d = 1'b0;
            age_d    = '0;
            state_d  = HOLD;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= EMPTY;
      paddr_q  <= '0;
      data_q   <= '0;
      be_q     <= '0;
      size_q   <= '0;
      merged_q <= 1'b0;
      age_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      data_q   <= data_d;
      be_q     <= be_d;
      size_q   <= size_d;
      merged_q <= merged_d;
      age_q    <= age_d;
    end
  end

  // D$ request driven straight from the entry registers, stable until grant
  assign d.req   = (state_q == ISSUE);
  assign d.paddr = merged_q ? {paddr_q[PLEN-1:3], 3'b000} : paddr_q;
  assign d.data  = data_q;
  assign d.be    = be_q;
  assign d.size  = merged_q ? 2'b11 : size_q;

  assign page_offset_matches_o = (state_q != EMPTY) && (page_offset_i[11:3] == paddr_q[11:3]);
  assign empty_o               = (state_q == EMPTY);

endmodule
